acc_buf_ctrl: RTL and testbench
===============================

Name: acc_buf_ctrl

Overview:
- Controller in front of the double-buffered accumulator memory: 256 entries x 64 bits per buffer, one registered buffer-select, 1-cycle synchronous read.
- Passes result writes from the systolic array through to the memory write port.
- Sequences drain commands into reads streamed out on a valid/ready interface.
- Performs SYNC buffer swaps only when the memory is quiescent, and holds off all accesses until the memory's registered select has settled.

Parameters:
ADDR_W, 8, accumulator address width (entries = 2**ADDR_W)
DATA_W, 64, accumulator word width (col1 + col0)
OUT_DEPTH, 2, output FIFO depth (>=2 needed for 1 word/cycle)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
wr_valid  in  1  array result write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
drain_start  in  1  1-cycle drain command pulse
drain_base  in  ADDR_W  first address to drain
drain_len  in  ADDR_W+1  word count, 0..256
drain_busy  out  1  drain active or pending swap
drain_done  out  1  1-cycle pulse, drain complete
out_valid  out  1  drain stream valid
out_ready  in  1  drain stream ready
out_data  out  DATA_W  drained word
out_last  out  1  final word of drain
sync_req  in  1  1-cycle buffer swap request
sync_done  out  1  1-cycle pulse, swap settled
acc_buf_sel  out  1  to memory buffer select
acc_wr_en  out  1  to memory
acc_wr_addr  out  ADDR_W  to memory
acc_wr_data  out  DATA_W  to memory
acc_rd_en  out  1  to memory
acc_rd_addr  out  ADDR_W  to memory
acc_rd_data  in  DATA_W  from memory, valid 1 cycle after acc_rd_en

Behaviour:
- Reset: state IDLE; FIFO empty; pending_sync=0; all outputs 0 (acc_buf_sel=0, wr_ready=0 during reset).
- Write path is combinational pass-through: acc_wr_en=wr_valid&wr_ready; addr/data forwarded.
  - wr_ready=1 in IDLE and DRAIN.
  - wr_ready=0 in SWAP and SETTLE.
- FSM states: IDLE, DRAIN, SWAP, SETTLE.
- IDLE:
  - drain_start with drain_len>0: latch base and len, go to DRAIN.
  - drain_start with drain_len=0: drain_done pulses next cycle, no reads.
  - Else if sync_req or pending_sync: go to SWAP.
  - drain_start and sync_req in the same cycle: drain wins, sync latched as pending_sync.
- DRAIN:
  - Issue acc_rd_en with acc_rd_addr=(base+issued) mod 256 when issued<len and fifo_count+inflight<OUT_DEPTH.
  - Returned data is pushed into the FIFO the following cycle.
  - Sustains 1 word/cycle while out_ready=1.
  - out_last=1 on word len-1. Address wraps modulo 256 (base 0xFE, len 4 -> FE,FF,00,01).
  - Exit when the last word handshakes: go to IDLE; drain_done pulses the next cycle.
  - drain_start during DRAIN is ignored.
  - sync_req during DRAIN sets pending_sync; drain_busy stays 1 until the swap completes.
- SWAP: toggle acc_buf_sel; go to SETTLE. No rd/wr issued.
- SETTLE: one cycle with no access (the memory registers select); sync_done=1 this cycle; clear pending_sync; go to IDLE.
- sync_req while in SWAP/SETTLE: ignored.
- out_valid=FIFO non-empty; out_data/out_last come from the FIFO head, stable while out_valid&!out_ready.
- drain_busy=(state!=IDLE)|pending_sync.
- Asynchronous reset mid-drain or mid-swap: immediate return to reset values. acc_buf_sel returns to 0; memory contents are untouched.

Optional Feature:
ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN
- Defined: each drained address is zero-written through the write port in the cycle after its read issues.
  - That cycle takes priority: wr_ready=0, acc_wr_data=0, acc_wr_addr=drained address.
  - Buffer is clean for the next accumulation.
- Undefined: no clear writes; wr_ready is never stalled in DRAIN.

Test Plan:
- Write 0x1111_0000_2222_0001 to addr 5, drain base=5 len=1 with out_ready=1 -> out_data equals the written word, out_last=1, drain_done pulses 1 cycle after the handshake.
- Drain base=0xFE len=4, out_ready=1 -> acc_rd_addr FE,FF,00,01 on 4 consecutive cycles; 4 consecutive out beats; out_last on the 4th.
- Drain len=8 with out_ready toggling 1,0,1,0 -> exactly 8 beats in address order; fifo_count+inflight never exceeds 2; no data lost.
- sync_req during an 8-word drain -> acc_buf_sel toggles only after the 8th beat; wr_ready=0 for exactly 2 cycles; sync_done pulses in SETTLE; a subsequent drain reads the other buffer.
- drain_start (len=0) -> drain_done next cycle, acc_rd_en never asserts.
- With ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN: drain base=3 len=2, then drain again -> second drain returns 0,0; wr_ready=0 on the 2 clear cycles. Assert rst_n low mid-drain -> out_valid=0, acc_buf_sel=0 immediately.

Source files
------------

// File: rtl/acc_buf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : acc_buf_ctrl                                                    |
// | Purpose  : Front-end controller for the double-buffered accumulator        |
// |            memory. Forwards array result writes, streams drain commands    |
// |            out through a small output FIFO, and swaps buffers only while   |
// |            the memory is quiescent.                                        |
// | Option   : ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN - zero-write each drained word   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module acc_buf_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 64,
   parameter int OUT_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              drain_start,
   input  logic [ADDR_W-1:0] drain_base,
   input  logic [ADDR_W:0]   drain_len,
   output logic              drain_busy,
   output logic              drain_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              sync_req,
   output logic              sync_done,
   output logic              acc_buf_sel,
   output logic              acc_wr_en,
   output logic [ADDR_W-1:0] acc_wr_addr,
   output logic [DATA_W-1:0] acc_wr_data,
   output logic              acc_rd_en,
   output logic [ADDR_W-1:0] acc_rd_addr,
   input  logic [DATA_W-1:0] acc_rd_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAIN  = 2'd1,
      S_SWAP   = 2'd2,
      S_SETTLE = 2'd3
   } state_t;

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1) + 1;
   localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   issued_q, issued_d;
   logic              pending_q, pending_d;
   logic              done_q, done_d;
   logic              sel_q, sel_d;
   logic              inflight_q;
   logic              infl_last_q;
`ifdef ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN
   logic [ADDR_W-1:0] infl_addr_q;
`endif

   // Output FIFO: each entry carries {last, data}
   logic [DATA_W:0]   fifo_mem [OUT_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              pop;
   logic [CNT_W-1:0]  occ;
   logic              rd_issue;
   logic [DATA_W:0]   head;
   logic              last_hs;
   logic              wr_open;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Read credit: a slot freed by this cycle's pop may be reused at once,
   // which is what lets a 2-deep FIFO sustain one word per cycle.
   always_comb begin
      pop      = (cnt_q != '0) && out_ready;
      occ      = cnt_q + CNT_W'(inflight_q) - CNT_W'(pop);
      rd_issue = (state_q == S_DRAIN) && (issued_q < len_q) && (occ < CNT_W'(OUT_DEPTH));
      head     = fifo_mem[rd_ptr_q];
      last_hs  = pop && head[DATA_W];
   end

   // Next-state logic for the controller FSM and drain bookkeeping
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      issued_d  = rd_issue ? issued_q + LEN_ONE : issued_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      sel_d     = sel_q;
      case (state_q)
         S_IDLE: begin
            if (drain_start) begin
               if (drain_len != '0) begin
                  base_d   = drain_base;
                  len_d    = drain_len;
                  issued_d = '0;
                  state_d  = S_DRAIN;
               end else begin
                  done_d = 1'b1;
               end
               if (sync_req) pending_d = 1'b1;
            end else if (sync_req || pending_q) begin
               state_d = S_SWAP;
            end
         end
         S_DRAIN: begin
            if (sync_req) pending_d = 1'b1;
            if (last_hs) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_SWAP: begin
            sel_d   = ~sel_q;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            pending_d = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers, FIFO pointers and read-pipeline tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         pending_q   <= 1'b0;
         done_q      <= 1'b0;
         sel_q       <= 1'b0;
         inflight_q  <= 1'b0;
         infl_last_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         pending_q   <= pending_d;
         done_q      <= done_d;
         sel_q       <= sel_d;
         inflight_q  <= rd_issue;
         infl_last_q <= (issued_q == len_q - LEN_ONE);
         if (inflight_q) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)        rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q       <= cnt_q + CNT_W'(inflight_q) - CNT_W'(pop);
      end
   end

`ifdef ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN
   // Remember the address of the read in flight so it can be zeroed next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) infl_addr_q <= '0;
      else        infl_addr_q <= acc_rd_addr;
   end
`endif

   // Capture returned read data into the FIFO one cycle after the read
   always_ff @(posedge clk) begin
      if (inflight_q) fifo_mem[wr_ptr_q] <= {infl_last_q, acc_rd_data};
   end

   // Write port: pass-through, closed during swap/settle and while in reset
   always_comb begin
      wr_open = rst_n && ((state_q == S_IDLE) || (state_q == S_DRAIN));
`ifdef ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN
      wr_ready    = wr_open && !inflight_q;
      acc_wr_en   = (wr_valid && wr_ready) || inflight_q;
      acc_wr_addr = inflight_q ? infl_addr_q : wr_addr;
      acc_wr_data = inflight_q ? '0 : wr_data;
`else
      wr_ready    = wr_open;
      acc_wr_en   = wr_valid && wr_ready;
      acc_wr_addr = wr_addr;
      acc_wr_data = wr_data;
`endif
   end

   // Read port, stream outputs and status
   always_comb begin
      acc_rd_en   = rd_issue;
      acc_rd_addr = base_q + issued_q[ADDR_W-1:0];
      out_valid   = (cnt_q != '0);
      out_data    = out_valid ? head[DATA_W-1:0] : '0;
      out_last    = out_valid && head[DATA_W];
      drain_busy  = (state_q != S_IDLE) || pending_q;
      drain_done  = done_q;
      sync_done   = (state_q == S_SETTLE);
      acc_buf_sel = sel_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_acc_buf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_acc_buf_ctrl                                                 |
// | Purpose  : Directed self-checking bench for acc_buf_ctrl with a behavioural |
// |            double-buffered memory (registered select, 1-cycle read).       |
// | Option   : ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN adds the clear-on-drain scenario |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_acc_buf_ctrl;

`ifdef ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN
   localparam int CLR = 1;
`else
   localparam int CLR = 0;
`endif

   logic        clk, rst_n;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic        drain_start;
   logic [7:0]  drain_base;
   logic [8:0]  drain_len;
   logic        drain_busy, drain_done;
   logic        out_valid, out_ready, out_last;
   logic [63:0] out_data;
   logic        sync_req, sync_done, acc_buf_sel;
   logic        acc_wr_en, acc_rd_en;
   logic [7:0]  acc_wr_addr, acc_rd_addr;
   logic [63:0] acc_wr_data, acc_rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   acc_buf_ctrl #(.ADDR_W(8), .DATA_W(64), .OUT_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
      .drain_busy(drain_busy), .drain_done(drain_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .sync_req(sync_req), .sync_done(sync_done), .acc_buf_sel(acc_buf_sel),
      .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
      .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural accumulator memory: two 256-entry buffers, registered select
   logic [63:0] mem [0:511];
   logic        mem_sel;
   always @(posedge clk) begin
      mem_sel <= acc_buf_sel;
      if (acc_wr_en) mem[{mem_sel, acc_wr_addr}] <= acc_wr_data;
      if (acc_rd_en) acc_rd_data <= mem[{mem_sel, acc_rd_addr}];
   end

   // Observations gathered by run_drain
   logic [63:0] beat_data[$];
   logic        beat_last[$];
   int          beat_cyc[$];
   logic [7:0]  rd_addr_q[$];
   int          rd_cyc[$];
   int          done_cyc, sel_chg_cyc, sync_done_cyc, wr_low_cnt, occ_max;
   logic        busy_at_done;
   logic        timed_out;

   task automatic write_word(input logic [7:0] a, input logic [63:0] d);
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // ready_mode: 0 = always ready, 1 = toggling 1,0,1,0; sync_at = cycle to pulse sync_req
   task automatic run_drain(input logic [7:0] base, input logic [8:0] len,
                            input int ready_mode, input int sync_at, input int extra);
      int   cyc = 0;
      int   issued = 0;
      int   popped = 0;
      logic sel0 = acc_buf_sel;
      beat_data.delete(); beat_last.delete(); beat_cyc.delete();
      rd_addr_q.delete(); rd_cyc.delete();
      done_cyc = -1; sel_chg_cyc = -1; sync_done_cyc = -1;
      wr_low_cnt = 0; occ_max = 0; busy_at_done = 1'b0; timed_out = 1'b0;
      forever begin
         @(negedge clk);
         drain_start = (cyc == 0);
         drain_base  = base;
         drain_len   = len;
         sync_req    = (cyc == sync_at);
         out_ready   = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         #1;
         if (acc_rd_en === 1'b1) begin
            rd_addr_q.push_back(acc_rd_addr); rd_cyc.push_back(cyc); issued++;
         end
         if (out_valid === 1'b1 && out_ready) begin
            beat_data.push_back(out_data); beat_last.push_back(out_last);
            beat_cyc.push_back(cyc); popped++;
         end
         if (issued - popped > occ_max) occ_max = issued - popped;
         if (wr_ready !== 1'b1) wr_low_cnt++;
         if (drain_done === 1'b1 && done_cyc < 0) begin
            done_cyc = cyc; busy_at_done = drain_busy;
         end
         if (sync_done === 1'b1 && sync_done_cyc < 0) sync_done_cyc = cyc;
         if (acc_buf_sel !== sel0 && sel_chg_cyc < 0) sel_chg_cyc = cyc;
         cyc++;
         if (done_cyc >= 0 && cyc > done_cyc + extra) break;
         if (cyc > 200) begin timed_out = 1'b1; break; end
      end
      drain_start = 1'b0; sync_req = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      drain_start = 1'b0; drain_base = '0; drain_len = '0;
      out_ready = 1'b1; sync_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (wr_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
      n_checks++; if (acc_buf_sel !== 1'b0) begin n_fail++; $display("FAIL reset_buf_sel got %b exp 0", acc_buf_sel); end
      n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_checks++; if (drain_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b exp 0", drain_busy); end
      n_checks++; if (drain_done !== 1'b0 || sync_done !== 1'b0 || acc_rd_en !== 1'b0)
         begin n_fail++; $display("FAIL reset_pulses got done=%b sync=%b rd=%b exp 0", drain_done, sync_done, acc_rd_en); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (wr_ready !== 1'b1)    begin n_fail++; $display("FAIL idle_wr_ready got %b exp 1", wr_ready); end
   endtask

   task automatic test_write_path;
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = 8'h05; wr_data = 64'h1111_0000_2222_0001;
      #1;
      n_checks++; if (acc_wr_en !== 1'b1 || acc_wr_addr !== 8'h05 || acc_wr_data !== 64'h1111_0000_2222_0001)
         begin n_fail++; $display("FAIL wr_pass got en=%b a=%h d=%h exp 1 05 1111000022220001", acc_wr_en, acc_wr_addr, acc_wr_data); end
      @(negedge clk); wr_valid = 1'b0; #1;
      n_checks++; if (acc_wr_en !== 1'b0)  begin n_fail++; $display("FAIL wr_idle_en got %b exp 0", acc_wr_en); end
   endtask

   task automatic test_single;
      run_drain(8'h05, 9'd1, 0, -1, 0);
      n_checks++; if (timed_out !== 1'b0 || beat_data.size() != 1)
         begin n_fail++; $display("FAIL single_beats got %0d timeout=%b exp 1", beat_data.size(), timed_out); end
      else begin
         n_checks++; if (beat_data[0] !== 64'h1111_0000_2222_0001 || beat_last[0] !== 1'b1)
            begin n_fail++; $display("FAIL single_data got %h last=%b exp 1111000022220001 1", beat_data[0], beat_last[0]); end
         n_checks++; if (beat_cyc[0] != 3 || done_cyc != 4)
            begin n_fail++; $display("FAIL single_timing got beat=%0d done=%0d exp 3 4", beat_cyc[0], done_cyc); end
      end
   endtask

   task automatic test_wrap;
      logic [7:0] ea [4];
      ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00; ea[3] = 8'h01;
      for (int i = 0; i < 4; i++) write_word(ea[i], 64'hD000_0000_0000_0000 + 64'(i));
      run_drain(8'hFE, 9'd4, 0, -1, 0);
      n_checks++; if (timed_out !== 1'b0 || rd_addr_q.size() != 4 || beat_data.size() != 4)
         begin n_fail++; $display("FAIL wrap_counts got rd=%0d beats=%0d exp 4 4", rd_addr_q.size(), beat_data.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++; if (rd_addr_q[i] !== ea[i] || rd_cyc[i] != 1 + i)
               begin n_fail++; $display("FAIL wrap_rd[%0d] got %h@%0d exp %h@%0d", i, rd_addr_q[i], rd_cyc[i], ea[i], 1 + i); end
            n_checks++; if (beat_data[i] !== 64'hD000_0000_0000_0000 + 64'(i) || beat_cyc[i] != 3 + i || beat_last[i] !== (i == 3))
               begin n_fail++; $display("FAIL wrap_beat[%0d] got %h@%0d last=%b", i, beat_data[i], beat_cyc[i], beat_last[i]); end
         end
         n_checks++; if (done_cyc != 7) begin n_fail++; $display("FAIL wrap_done got %0d exp 7", done_cyc); end
      end
      n_checks++; if (wr_low_cnt != 4 * CLR) begin n_fail++; $display("FAIL wrap_wr_low got %0d exp %0d", wr_low_cnt, 4 * CLR); end
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < 8; i++) write_word(8'h20 + 8'(i), 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0101);
      run_drain(8'h20, 9'd8, 1, -1, 0);
      n_checks++; if (timed_out !== 1'b0 || beat_data.size() != 8 || rd_addr_q.size() != 8)
         begin n_fail++; $display("FAIL bp_counts got beats=%0d rd=%0d exp 8 8", beat_data.size(), rd_addr_q.size()); end
      else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++; if (beat_data[i] !== 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0101 || rd_addr_q[i] !== 8'h20 + 8'(i) || beat_last[i] !== (i == 7))
               begin n_fail++; $display("FAIL bp_beat[%0d] got %h a=%h last=%b", i, beat_data[i], rd_addr_q[i], beat_last[i]); end
         end
      end
      n_checks++; if (occ_max > 2) begin n_fail++; $display("FAIL bp_occupancy got %0d exp <=2", occ_max); end
   endtask

   task automatic test_zero_len;
      run_drain(8'h40, 9'd0, 0, -1, 0);
      n_checks++; if (timed_out !== 1'b0 || done_cyc != 1 || rd_addr_q.size() != 0 || beat_data.size() != 0)
         begin n_fail++; $display("FAIL zero_len got done=%0d rd=%0d beats=%0d exp 1 0 0", done_cyc, rd_addr_q.size(), beat_data.size()); end
   endtask

   task automatic test_sync_idle;
      @(negedge clk); sync_req = 1'b1; #1;
      n_checks++; if (sync_done !== 1'b0 || wr_ready !== 1'b1)
         begin n_fail++; $display("FAIL sync_c0 got sd=%b rdy=%b exp 0 1", sync_done, wr_ready); end
      @(negedge clk); sync_req = 1'b0; #1;
      n_checks++; if (wr_ready !== 1'b0 || drain_busy !== 1'b1 || acc_buf_sel !== 1'b0)
         begin n_fail++; $display("FAIL sync_swap got rdy=%b busy=%b sel=%b exp 0 1 0", wr_ready, drain_busy, acc_buf_sel); end
      @(negedge clk); #1;
      n_checks++; if (sync_done !== 1'b1 || acc_buf_sel !== 1'b1 || wr_ready !== 1'b0)
         begin n_fail++; $display("FAIL sync_settle got sd=%b sel=%b rdy=%b exp 1 1 0", sync_done, acc_buf_sel, wr_ready); end
      @(negedge clk); #1;
      n_checks++; if (sync_done !== 1'b0 || wr_ready !== 1'b1 || drain_busy !== 1'b0)
         begin n_fail++; $display("FAIL sync_after got sd=%b rdy=%b busy=%b exp 0 1 0", sync_done, wr_ready, drain_busy); end
      write_word(8'h31, 64'hB1B1_B1B1_0000_0031);   // lands in buffer 1
      @(negedge clk); sync_req = 1'b1;
      @(negedge clk); sync_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (acc_buf_sel !== 1'b0) begin n_fail++; $display("FAIL sync_back got %b exp 0", acc_buf_sel); end
   endtask

   task automatic test_sync_during_drain;
      int lb;
      for (int i = 0; i < 8; i++) write_word(8'h30 + 8'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
      run_drain(8'h30, 9'd8, 0, 3, 4);
      n_checks++; if (timed_out !== 1'b0 || beat_data.size() != 8)
         begin n_fail++; $display("FAIL sd_beats got %0d exp 8", beat_data.size()); end
      else begin
         lb = beat_cyc[7];
         for (int i = 0; i < 8; i++) begin
            n_checks++; if (beat_data[i] !== 64'hA5A5_0000_0000_0000 + 64'(i))
               begin n_fail++; $display("FAIL sd_data[%0d] got %h", i, beat_data[i]); end
         end
         n_checks++; if (done_cyc != lb + 1 || busy_at_done !== 1'b1)
            begin n_fail++; $display("FAIL sd_done got %0d busy=%b exp %0d 1", done_cyc, busy_at_done, lb + 1); end
         n_checks++; if (sel_chg_cyc != lb + 3 || sync_done_cyc != lb + 3)
            begin n_fail++; $display("FAIL sd_swap got sel@%0d sd@%0d exp %0d", sel_chg_cyc, sync_done_cyc, lb + 3); end
      end
      n_checks++; if (wr_low_cnt != 2 + 8 * CLR) begin n_fail++; $display("FAIL sd_wr_low got %0d exp %0d", wr_low_cnt, 2 + 8 * CLR); end
      run_drain(8'h31, 9'd1, 0, -1, 0);
      n_checks++; if (beat_data.size() != 1 || acc_buf_sel !== 1'b1)
         begin n_fail++; $display("FAIL sd_other_cnt got %0d sel=%b exp 1 1", beat_data.size(), acc_buf_sel); end
      else begin
         n_checks++; if (beat_data[0] !== 64'hB1B1_B1B1_0000_0031)
            begin n_fail++; $display("FAIL sd_other_buf got %h exp b1b1b1b100000031", beat_data[0]); end
      end
   endtask

`ifdef ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN
   task automatic test_clear;
      write_word(8'h03, 64'hE0E0_0000_0000_0003);
      write_word(8'h04, 64'hE1E1_0000_0000_0004);
      run_drain(8'h03, 9'd2, 0, -1, 0);
      n_checks++; if (beat_data.size() != 2 || wr_low_cnt != 2)
         begin n_fail++; $display("FAIL clr_first got beats=%0d wr_low=%0d exp 2 2", beat_data.size(), wr_low_cnt); end
      else begin
         n_checks++; if (beat_data[0] !== 64'hE0E0_0000_0000_0003 || beat_data[1] !== 64'hE1E1_0000_0000_0004)
            begin n_fail++; $display("FAIL clr_first_data got %h %h", beat_data[0], beat_data[1]); end
      end
      run_drain(8'h03, 9'd2, 0, -1, 0);
      n_checks++; if (beat_data.size() != 2)
         begin n_fail++; $display("FAIL clr_second_cnt got %0d exp 2", beat_data.size()); end
      else begin
         n_checks++; if (beat_data[0] !== 64'h0 || beat_data[1] !== 64'h0)
            begin n_fail++; $display("FAIL clr_second_data got %h %h exp 0 0", beat_data[0], beat_data[1]); end
      end
   endtask
`endif

   task automatic test_reset_mid_drain;
      @(negedge clk);
      out_ready = 1'b0; drain_start = 1'b1; drain_base = 8'h31; drain_len = 9'd8;
      @(negedge clk); drain_start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1 || drain_busy !== 1'b1 || acc_buf_sel !== 1'b1)
         begin n_fail++; $display("FAIL mid_pre got v=%b busy=%b sel=%b exp 1 1 1", out_valid, drain_busy, acc_buf_sel); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || acc_buf_sel !== 1'b0 || drain_busy !== 1'b0 || wr_ready !== 1'b0 || acc_rd_en !== 1'b0)
         begin n_fail++; $display("FAIL mid_reset got v=%b sel=%b busy=%b rdy=%b rd=%b exp 0", out_valid, acc_buf_sel, drain_busy, wr_ready, acc_rd_en); end
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (wr_ready !== 1'b1 || out_valid !== 1'b0)
         begin n_fail++; $display("FAIL mid_release got rdy=%b v=%b exp 1 0", wr_ready, out_valid); end
   endtask

   initial begin
      test_reset();
      test_write_path();
      test_single();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_sync_idle();
      test_sync_during_drain();
`ifdef ACC_BUF_CTRL_CLEAR_ON_DRAIN_EN
      test_clear();
`endif
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
